// File: rtl/uart_send_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ send requesters, each with a one-entry slot.
// Define UART_ARB_WORD_SPLIT_EN to send all four bytes of a slot (LSB first) per grant.
module uart_send_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [N_REQ-1:0]    req_en,
    input  logic [32*N_REQ-1:0] req_content,
    output logic [N_REQ-1:0]    req_busy,
    output logic                tx_en,
    output logic [31:0]         tx_content,
    input  logic                tx_busy
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, SEND, GUARD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  slot_valid_q, slot_valid_d;
    logic [DW-1:0]     slot_data_q [N_REQ];
    logic [DW-1:0]     slot_data_d [N_REQ];
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic              tx_en_q, tx_en_d;
    logic [DW-1:0]     tx_content_q, tx_content_d;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     cand;
    logic              pick_vld;
    logic              last_xfer;

`ifdef UART_ARB_WORD_SPLIT_EN
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [DW-1:0]     grant_word;
    logic [7:0]        grant_byte;

    assign grant_word = slot_data_q[grant_q];
    assign grant_byte = grant_word[{byte_cnt_q, 3'b000} +: 8];
    assign last_xfer  = (byte_cnt_q == 2'd3);
`else
    assign last_xfer  = 1'b1;
`endif

    assign req_busy   = slot_valid_q;
    assign tx_en      = tx_en_q;
    assign tx_content = tx_content_q;

    // First valid slot at or after rr_ptr; the last hit in the descending scan wins.
    always_comb begin
        pick_idx = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = PW'((32'(rr_ptr_q) + N_REQ - 1 - k) % N_REQ);
            if (slot_valid_q[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        slot_data_d  = slot_data_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        tx_en_d      = 1'b0;
        tx_content_d = tx_content_q;
`ifdef UART_ARB_WORD_SPLIT_EN
        byte_cnt_d   = byte_cnt_q;
`endif

        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_en[i] && !slot_valid_q[i]) begin
                slot_valid_d[i] = 1'b1;
                slot_data_d[i]  = req_content[32*i +: 32];
            end
        end

        unique case (state_q)
            IDLE: begin
                if (pick_vld && !tx_busy) begin
                    grant_d = pick_idx;
                    tx_en_d = 1'b1;
`ifdef UART_ARB_WORD_SPLIT_EN
                    tx_content_d = {24'b0, slot_data_q[pick_idx][7:0]};
`else
                    tx_content_d = slot_data_q[pick_idx];
`endif
                    state_d = SEND;
                end
            end
            SEND: begin
                state_d = GUARD;
`ifdef UART_ARB_WORD_SPLIT_EN
                byte_cnt_d = byte_cnt_q + 2'd1;
`endif
                if (last_xfer) begin
                    slot_valid_d[grant_q] = 1'b0;
                    rr_ptr_d = (grant_q == PW'(N_REQ - 1)) ? '0 : grant_q + PW'(1);
                end
            end
            GUARD: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_d = IDLE;
`ifdef UART_ARB_WORD_SPLIT_EN
                    // byte_cnt wraps to 0 after the last byte, so nonzero means the word is unfinished
                    if (byte_cnt_q != 2'd0) begin
                        tx_en_d      = 1'b1;
                        tx_content_d = {24'b0, grant_byte};
                        state_d      = SEND;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            slot_valid_q <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            tx_en_q      <= 1'b0;
            tx_content_q <= '0;
            for (int unsigned i = 0; i < N_REQ; i++) begin
                slot_data_q[i] <= '0;
            end
`ifdef UART_ARB_WORD_SPLIT_EN
            byte_cnt_q   <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_data_q  <= slot_data_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            tx_en_q      <= tx_en_d;
            tx_content_q <= tx_content_d;
`ifdef UART_ARB_WORD_SPLIT_EN
            byte_cnt_q   <= byte_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_uart_send_arbiter.sv
// Self-checking bench for uart_send_arbiter: timestamp-based reference model plus directed scenarios.
// Also exercises the UART_ARB_WORD_SPLIT_EN build when that macro is defined.
module tb_uart_send_arbiter;
    localparam int unsigned N = 4;
`ifdef UART_ARB_WORD_SPLIT_EN
    localparam int BYTES = 4;
`else
    localparam int BYTES = 1;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      req_en;
    logic [32*N-1:0]   req_content;
    logic [N-1:0]      req_busy;
    logic              tx_en;
    logic [31:0]       tx_content;
    logic              tx_busy;

    always #5 clk = ~clk;

    uart_send_arbiter #(.N_REQ(N)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_en      (req_en),
        .req_content (req_content),
        .req_busy    (req_busy),
        .tx_en       (tx_en),
        .tx_content  (tx_content),
        .tx_busy     (tx_busy)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] byte_of(input logic [31:0] w, input int idx);
        return {24'b0, w[8*idx +: 8]};
    endfunction

    // ---------------- reference model: slots plus send timestamps ----------------
    logic [N-1:0] m_valid;
    logic [31:0]  m_data [N];
    int           m_ptr, m_cur, m_left;
    logic         m_txen;
    logic [31:0]  m_txc;
    logic         engaged, drained;
    int           last_en, idle_from;
    logic [N-1:0] nv;
    logic         nen;
    int           pick;
    logic [7:0]   sent [$];

    task automatic model_reset();
        m_valid = '0;
        for (int i = 0; i < int'(N); i++) m_data[i] = '0;
        m_ptr = 0; m_cur = 0; m_left = 0;
        m_txen = 1'b0; m_txc = '0;
        engaged = 1'b0; drained = 1'b1;
        last_en = 0; idle_from = 0;
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            model_reset();
            check("reset_req_busy", 32'(req_busy), 32'(m_valid));
            check("reset_tx_en", 32'(tx_en), 32'(m_txen));
            check("reset_tx_content", tx_content, m_txc);
        end else begin
            check("req_busy", 32'(req_busy), 32'(m_valid));
            check("tx_en", 32'(tx_en), 32'(m_txen));
            check("tx_content", tx_content, m_txc);
            if (tx_en) sent.push_back(tx_content[7:0]);

            nv  = m_valid;
            nen = 1'b0;
            if (m_txen) begin
                last_en = cyc;
                drained = 1'b0;
                if (m_left == 0) begin
                    nv[m_cur] = 1'b0;
                    m_ptr = (m_cur + 1) % int'(N);
                end
            end
            // Transmitter is considered free at the first idle tx_busy two or more cycles after a send.
            if (engaged && !drained && cyc >= last_en + 2 && !tx_busy) begin
                drained = 1'b1;
                if (m_left > 0) begin
                    m_left--;
                    nen   = 1'b1;
                    m_txc = byte_of(m_data[m_cur], BYTES - 1 - m_left);
                end else begin
                    engaged   = 1'b0;
                    idle_from = cyc + 1;
                end
            end else if (!engaged && cyc >= idle_from && !tx_busy && m_valid != '0) begin
                pick = 0;
                for (int k = int'(N) - 1; k >= 0; k--)
                    if (m_valid[(m_ptr + k) % int'(N)]) pick = (m_ptr + k) % int'(N);
                m_cur   = pick;
                m_left  = BYTES - 1;
                engaged = 1'b1;
                drained = 1'b1;
                nen     = 1'b1;
                m_txc   = (BYTES == 1) ? m_data[pick] : byte_of(m_data[pick], 0);
            end
            for (int i = 0; i < int'(N); i++) begin
                if (req_en[i] && !m_valid[i]) begin
                    nv[i]     = 1'b1;
                    m_data[i] = req_content[32*i +: 32];
                end
            end
            m_valid = nv;
            m_txen  = nen;
        end
    end

    // ---------------- stimulus ----------------
    int   busy_len   = 10;
    int   busy_cnt   = 0;
    logic prev_tx_en = 1'b0;

    // Advance one cycle; the transmitter model raises tx_busy for busy_len cycles after each tx_en.
    task automatic tick();
        @(posedge clk);
        #1;
        if (prev_tx_en) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        prev_tx_en = tx_en;
        tx_busy = (busy_cnt > 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        req_en = '0;
        busy_cnt = 0;
        prev_tx_en = 1'b0;
        tx_busy = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        sent.delete();
    endtask

    logic [7:0] exp_g [4];
    int         en_cycles [$];
    int         n_en;
    logic       got;

    initial begin
        rstn = 1'b0;
        req_en = '1;
        req_content = '1;
        tx_busy = 1'b0;

        // 1: reset holds everything clear even with every en asserted
        repeat (3) tick();
        check("t1_req_busy", 32'(req_busy), 32'h0);
        check("t1_tx_en", 32'(tx_en), 32'h0);
        check("t1_tx_content", tx_content, 32'h0);
        req_en = '0;
        rstn = 1'b1;
        sent.delete();
        repeat (20) tick();
        check("t1_nothing_sent", 32'(sent.size()), 32'h0);

        // 2: single port, uncontended latency
        do_reset();
        busy_len = 10;
        tick();
        req_en[2] = 1'b1;
        req_content[64 +: 32] = 32'h0000_00A5;
        tick();
        req_en = '0;
        check("t2_busy_t1", 32'(req_busy[2]), 32'h1);
        check("t2_txen_t1", 32'(tx_en), 32'h0);
        tick();
        check("t2_txen_t2", 32'(tx_en), 32'h1);
        check("t2_byte_t2", 32'(tx_content[7:0]), 32'hA5);
        check("t2_busy_t2", 32'(req_busy[2]), 32'h1);
        tick();
        check("t2_txen_t3", 32'(tx_en), 32'h0);
`ifdef UART_ARB_WORD_SPLIT_EN
        check("t2_busy_t3", 32'(req_busy[2]), 32'h1);
`else
        check("t2_busy_t3", 32'(req_busy[2]), 32'h0);
`endif
        repeat (60) tick();

        // 3: contention from rr_ptr=0, then immediate refill of port 0
        do_reset();
        busy_len = 3;
        tick();
        req_en = 4'b1011;
        req_content = {32'h33, 32'h0, 32'h31, 32'h30};
        tick();
        req_en = '0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (!req_busy[0]) got = 1'b1;
        end
        check("t3_slot0_released", 32'(got), 32'h1);
        req_en[0] = 1'b1;
        req_content[0 +: 32] = 32'h40;
        tick();
        req_en = '0;
        repeat (80) tick();
        exp_g = '{8'h30, 8'h31, 8'h33, 8'h40};
        check("t3_count", 32'(sent.size()), 32'(4 * BYTES));
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_grant%0d", i),
                  (i * BYTES < sent.size()) ? 32'(sent[i * BYTES]) : 32'hDEAD, 32'(exp_g[i]));

        // 4: en while busy is dropped
        do_reset();
        busy_len = 10;
        tick();
        req_en[1] = 1'b1;
        req_content[32 +: 32] = 32'h11;
        tick();
        req_content[32 +: 32] = 32'h22;
        check("t4_busy_on_second_en", 32'(req_busy[1]), 32'h1);
        tick();
        req_en = '0;
        repeat (60) tick();
        check("t4_count", 32'(sent.size()), 32'(BYTES));
        check("t4_byte", (sent.size() > 0) ? 32'(sent[0]) : 32'hDEAD, 32'h11);

        // 5: en in the releasing SEND cycle is ignored, one cycle later is accepted
        do_reset();
        busy_len = 10;
        tick();
        req_en[0] = 1'b1;
        req_content[0 +: 32] = 32'h55;
        tick();
        req_en = '0;
        n_en = 0;
        got = 1'b0;
        for (int i = 0; i < 80 && !got; i++) begin
            tick();
            if (tx_en) n_en++;
            if (tx_en && n_en == BYTES) got = 1'b1;
        end
        check("t5_release_send_seen", 32'(got), 32'h1);
        req_en[0] = 1'b1;
        req_content[0 +: 32] = 32'h66;
        tick();
        check("t5_overlap_dropped", 32'(req_busy[0]), 32'h0);
        req_content[0 +: 32] = 32'h77;
        tick();
        req_en = '0;
        check("t5_next_accepted", 32'(req_busy[0]), 32'h1);
        repeat (60) tick();
        check("t5_count", 32'(sent.size()), 32'(2 * BYTES));
        check("t5_first", (sent.size() > 0) ? 32'(sent[0]) : 32'hDEAD, 32'h55);
        check("t5_second", (sent.size() > BYTES) ? 32'(sent[BYTES]) : 32'hDEAD, 32'h77);

        // tx_busy never rising: spacing of consecutive tx_en pulses
        do_reset();
        busy_len = 0;
        tick();
        req_en = 4'b0011;
        req_content = {32'h0, 32'h0, 32'h0000_00B1, 32'h0000_00B0};
        tick();
        req_en = '0;
        en_cycles.delete();
        for (int i = 0; i < 40; i++) begin
            if (tx_en) en_cycles.push_back(cyc);
            tick();
        end
        check("t7_pulses", 32'(en_cycles.size()), 32'(2 * BYTES));
        check("t7_spacing", (en_cycles.size() > 1) ? 32'(en_cycles[1] - en_cycles[0]) : 32'hDEAD,
              (BYTES == 1) ? 32'd4 : 32'd3);

`ifdef UART_ARB_WORD_SPLIT_EN
        // 6: word split order, no preemption, mid-word reset
        do_reset();
        busy_len = 10;
        tick();
        req_en[1] = 1'b1;
        req_content[32 +: 32] = 32'hDEAD_BEEF;
        tick();
        req_en = '0;
        repeat (3) tick();
        req_en[0] = 1'b1;
        req_content[0 +: 32] = 32'h1234_5678;
        tick();
        req_en = '0;
        repeat (110) tick();
        check("t6_count", 32'(sent.size()), 32'd8);
        exp_g = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 4; i++)
            check($sformatf("t6_byte%0d", i), (i < sent.size()) ? 32'(sent[i]) : 32'hDEAD, 32'(exp_g[i]));
        check("t6_port0_after_word", (sent.size() > 4) ? 32'(sent[4]) : 32'hDEAD, 32'h78);

        do_reset();
        tick();
        req_en[2] = 1'b1;
        req_content[64 +: 32] = 32'hCAFE_F00D;
        req_en[3] = 1'b1;
        req_content[96 +: 32] = 32'h0000_0033;
        tick();
        req_en = '0;
        repeat (14) tick();
        check("t6_midword_started", 32'(sent.size() > 0), 32'h1);
        rstn = 1'b0;
        #1;
        check("t6_async_tx_en", 32'(tx_en), 32'h0);
        check("t6_async_slots", 32'(req_busy), 32'h0);
        repeat (2) tick();
        rstn = 1'b1;
        sent.delete();
        repeat (30) tick();
        check("t6_nothing_after_reset", 32'(sent.size()), 32'h0);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
